// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle MIPS main controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mc_pkg;

  // Opcode field values (IR[31:26]) recognised by the dispatcher
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // Controller states; 12-15 are never entered and recover to FETCH
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_e;

  // alu_op as consumed by the downstream ALU control decoder
  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  // ALU B-operand select
  localparam logic [1:0] SRC_B_REG     = 2'b00;
  localparam logic [1:0] SRC_B_FOUR    = 2'b01;
  localparam logic [1:0] SRC_B_IMM     = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

  // PC next-value select
  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  // All datapath strobes driven by the controller
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  // States that stall on mem_ready and therefore run the wait counter
  function automatic logic is_mem_wait(state_e s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/mc_out_decode.sv
// State-to-strobe decode for the main controller, with reset gating of every strobe.
// Latency: purely combinational.
// Backpressure: only FETCH looks at mem_ready (IR/PC load on the completing cycle).
import mc_pkg::*;

module mc_out_decode (
  input  logic   rst_n,
  input  state_e state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  // Moore decode of the current state; reset forces every strobe low
  always_comb begin
    ctrl           = '0;
    ctrl.alu_src_b = SRC_B_REG;
    ctrl.alu_op    = ALU_OP_ADD;
    ctrl.pc_source = PC_SRC_ALU;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRC_B_FOUR;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      // Branch target is precomputed here into ALUOut
      S_DECODE: ctrl.alu_src_b = SRC_B_IMM_SH2;
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_IMM;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALU_OP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = ALU_OP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PC_SRC_ALUOUT;
      end
      S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_IMM;
      end
      S_ADDIWB: ctrl.reg_write = 1'b1;
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PC_SRC_JUMP;
      end
      default: ;
    endcase
    if (!rst_n) ctrl = '0;
  end

endmodule

// File: rtl/mc_main_ctrl.sv
// Main control FSM of the multicycle MIPS datapath; optional jump support under MC_JUMP_EN.
// Latency: beq/j 3, R/addi/sw 4, lw 5 cycles, plus one cycle per mem_ready-low wait.
// Backpressure: FETCH/MEMRD/MEMWR hold until mem_ready; long waits raise sticky mem_timeout.
import mc_pkg::*;

module mc_main_ctrl #(
  parameter int MEM_WAIT_MAX = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic [3:0] state,
  output logic       illegal_op,
  output logic       mem_timeout
);

  localparam logic [7:0] WAIT_LIMIT = 8'(MEM_WAIT_MAX);

  state_e     state_q, state_d;
  logic       illegal_set;
  logic       waiting;
  logic [7:0] wait_cnt_q;
  logic       illegal_q, timeout_q;
  ctrl_t      ctrl;

  assign waiting = is_mem_wait(state_q) && !mem_ready;

  // Next-state selection and opcode dispatch
  always_comb begin
    state_d     = state_q;
    illegal_set = 1'b0;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     state_d = S_EXEC;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
`ifdef MC_JUMP_EN
          OP_J:         state_d = S_JUMP;
`else
          OP_J: begin
            state_d     = S_FETCH;
            illegal_set = 1'b1;
          end
`endif
          default: begin
            state_d     = S_FETCH;
            illegal_set = 1'b1;
          end
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWR:  if (mem_ready) state_d = S_FETCH;
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      default:  state_d = S_FETCH;
    endcase
  end

  // State register, wait counter and sticky flags. The counter is zero whenever a
  // wait state is entered; mem_timeout fires on a waiting cycle that finds it already
  // at the limit, i.e. once the wait has gone past MEM_WAIT_MAX cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_FETCH;
      wait_cnt_q <= '0;
      illegal_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (illegal_set) illegal_q <= 1'b1;
      if (waiting) begin
        if (wait_cnt_q == WAIT_LIMIT) timeout_q <= 1'b1;
        else                          wait_cnt_q <= wait_cnt_q + 8'd1;
      end else begin
        wait_cnt_q <= '0;
      end
    end
  end

  mc_out_decode u_out_decode (
    .rst_n     (rst_n),
    .state     (state_q),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign i_or_d        = ctrl.i_or_d;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign ir_write      = ctrl.ir_write;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign reg_dst       = ctrl.reg_dst;
  assign reg_write     = ctrl.reg_write;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_op        = ctrl.alu_op;
  assign pc_source     = ctrl.pc_source;
  assign state         = state_q;
  assign illegal_op    = illegal_q;
  assign mem_timeout   = timeout_q;

endmodule

// File: tb/tb_mc_main_ctrl.sv
// Self-checking bench for mc_main_ctrl: directed instruction walks, then random traffic
// compared every cycle against a route-table model of the controller.
// Inputs change 1 time unit after the rising edge; outputs are sampled 2 units later.
module tb_mc_main_ctrl;

  localparam int MAXW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, mem_ready;
  logic [5:0] opcode;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;
  logic       illegal_op, mem_timeout;

  mc_main_ctrl #(.MEM_WAIT_MAX(MAXW)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .state(state), .illegal_op(illegal_op),
    .mem_timeout(mem_timeout)
  );

  int checks = 0;
  int passed = 0;

  // Model: expected strobe word per state, the remaining route of the current
  // instruction, a count of consecutive waiting cycles and the two sticky flags.
  // Word layout: pw pwc iod mr mw irw m2r rd rw | src_a | src_b | alu_op | pc_src
  logic [15:0] tbl [12];
  int          m_state = 0;
  int          m_w = 0;
  bit          m_ill = 0;
  bit          m_to = 0;
  int          route[$];
  logic [5:0]  cur_op;

  int lw_st [5] = '{0, 1, 2, 3, 4};
  int r_st  [4] = '{0, 1, 6, 7};
  int b_st  [3] = '{0, 1, 8};

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
  endtask

  function automatic logic [15:0] dut_vec();
    return {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
            mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};
  endfunction

  function automatic logic [15:0] exp_vec();
    logic [15:0] v;
    if (!rst_n) return 16'h0000;
    v = tbl[m_state];
    if (m_state == 0) begin
      v[15] = mem_ready;
      v[10] = mem_ready;
    end
    return v;
  endfunction

  task automatic compare();
    chk("state", 16'(state), 16'(m_state));
    chk("illegal_op", 16'(illegal_op), 16'(m_ill));
    chk("mem_timeout", 16'(mem_timeout), 16'(m_to));
    chk("strobes", dut_vec(), exp_vec());
  endtask

  // Advance the model across one rising edge using the inputs held at that edge
  task automatic model_advance();
    if (!rst_n) begin
      m_state = 0; m_w = 0; m_ill = 0; m_to = 0;
      route.delete();
      return;
    end
    if ((m_state == 0 || m_state == 3 || m_state == 5) && !mem_ready) begin
      m_w++;
      if (m_w > MAXW) m_to = 1;
      return;
    end
    m_w = 0;
    if (m_state == 0) begin
      m_state = 1;
      return;
    end
    if (m_state == 1) begin
      case (opcode)
        6'b000000: route = '{6, 7};
        6'b100011: route = '{2, 3, 4};
        6'b101011: route = '{2, 5};
        6'b000100: route = '{8};
        6'b001000: route = '{9, 10};
`ifdef MC_JUMP_EN
        6'b000010: route = '{11};
`endif
        default:   route.delete();
      endcase
      if (route.size() == 0) m_ill = 1;
    end
    m_state = (route.size() != 0) ? route.pop_front() : 0;
  endtask

  task automatic cyc(input logic r, input logic [5:0] op, input logic rdy);
    rst_n = r; opcode = op; mem_ready = rdy;
    #2;
    compare();
  endtask

  task automatic tick();
    @(posedge clk);
    model_advance();
    #1;
  endtask

  function automatic logic [5:0] pick_op();
    case ($urandom_range(7))
      0: return 6'b000000;
      1: return 6'b100011;
      2: return 6'b101011;
      3: return 6'b000100;
      4: return 6'b001000;
      5: return 6'b000010;
      6: return 6'b111111;
      default: return 6'($urandom_range(63));
    endcase
  endfunction

  initial begin
    tbl[0]  = 16'b000100000_0_01_00_00;
    tbl[1]  = 16'b000000000_0_11_00_00;
    tbl[2]  = 16'b000000000_1_10_00_00;
    tbl[3]  = 16'b001100000_0_00_00_00;
    tbl[4]  = 16'b000000101_0_00_00_00;
    tbl[5]  = 16'b001010000_0_00_00_00;
    tbl[6]  = 16'b000000000_1_00_10_00;
    tbl[7]  = 16'b000000011_0_00_00_00;
    tbl[8]  = 16'b010000000_1_00_01_01;
    tbl[9]  = 16'b000000000_1_10_00_00;
    tbl[10] = 16'b000000001_0_00_00_00;
    tbl[11] = 16'b100000000_0_00_00_10;

    rst_n = 1'b0; opcode = 6'b100011; mem_ready = 1'b1;
    @(posedge clk); #1;

    // Held in reset: strobes gated, state at FETCH
    cyc(1'b0, 6'b100011, 1'b1);
    chk("rst_mem_read", 16'(mem_read), 16'd0);
    chk("rst_state", 16'(state), 16'd0);
    tick();

    // lw with memory always ready
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 6'b100011, 1'b1);
      chk("lw_state", 16'(state), 16'(lw_st[i]));
      chk("lw_reg_write", 16'(reg_write), 16'(i == 4));
      tick();
    end

    // R-type (sub via funct)
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 6'b000000, 1'b1);
      chk("r_state", 16'(state), 16'(r_st[i]));
      if (i == 2) chk("r_alu_op", 16'(alu_op), 16'd2);
      if (i == 3) chk("r_reg_dst", 16'(reg_dst), 16'd1);
      tick();
    end

    // beq
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 6'b000100, 1'b1);
      chk("beq_state", 16'(state), 16'(b_st[i]));
      if (i == 2) begin
        chk("beq_alu_op", 16'(alu_op), 16'd1);
        chk("beq_pc_write_cond", 16'(pc_write_cond), 16'd1);
        chk("beq_pc_source", 16'(pc_source), 16'd1);
      end
      tick();
    end

    // FETCH stalls for 3 cycles, which exceeds a limit of 2
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 6'b000010, 1'b0);
      chk("wait_ir_write", 16'(ir_write), 16'd0);
      chk("wait_state", 16'(state), 16'd0);
      tick();
    end
    cyc(1'b1, 6'b000010, 1'b1);
    chk("wait_ir_write_done", 16'(ir_write), 16'd1);
    chk("wait_timeout", 16'(mem_timeout), 16'd1);
    tick();

    // Jump opcode in DECODE: no write strobes here
    cyc(1'b1, 6'b000010, 1'b1);
    chk("dec_state", 16'(state), 16'd1);
    chk("dec_writes", 16'({pc_write, reg_write, mem_write, ir_write}), 16'd0);
    tick();
`ifdef MC_JUMP_EN
    cyc(1'b1, 6'b000010, 1'b1);
    chk("j_state", 16'(state), 16'd11);
    chk("j_pc_write", 16'(pc_write), 16'd1);
    chk("j_pc_source", 16'(pc_source), 16'd2);
    chk("j_illegal", 16'(illegal_op), 16'd0);
    tick();
    cyc(1'b1, 6'b000010, 1'b1);
    tick();
`else
    cyc(1'b1, 6'b000010, 1'b1);
    chk("j_state", 16'(state), 16'd0);
    chk("j_illegal", 16'(illegal_op), 16'd1);
    tick();
`endif

    // Unknown opcode: back to FETCH, illegal_op sticky
    cyc(1'b1, 6'b111111, 1'b1);
    tick();
    cyc(1'b1, 6'b111111, 1'b0);
    chk("ill_state", 16'(state), 16'd0);
    chk("ill_flag", 16'(illegal_op), 16'd1);
    tick();
    cyc(1'b1, 6'b111111, 1'b1);
    chk("ill_sticky", 16'(illegal_op), 16'd1);
    tick();

    // sw interrupted by reset in MEMWR
    cyc(1'b1, 6'b101011, 1'b1);
    tick();
    cyc(1'b1, 6'b101011, 1'b1);
    tick();
    cyc(1'b0, 6'b101011, 1'b1);
    chk("sw_rst_state", 16'(state), 16'd5);
    chk("sw_rst_mem_write", 16'(mem_write), 16'd0);
    tick();
    cyc(1'b1, 6'b101011, 1'b1);
    chk("sw_after_state", 16'(state), 16'd0);
    chk("sw_after_flags", 16'({illegal_op, mem_timeout}), 16'd0);
    tick();

    // Random traffic; opcode only changes while the model sits in FETCH
    cur_op = 6'b101011;
    for (int n = 0; n < 3000; n++) begin
      if (m_state == 0) cur_op = pick_op();
      cyc(($urandom_range(99) >= 2) ? 1'b1 : 1'b0, cur_op,
          ($urandom_range(99) < 65) ? 1'b1 : 1'b0);
      tick();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
